i2s_audio_rx: RTL and testbench
===============================

# i2s_audio_rx

Receive-side I2S deserialiser for external audio sources such as a cassette/line-in ADC or a codec loopback. It samples BCLK/LRCLK/SDATA pins, all asynchronous to the system clock, in the single 108 MHz system clock domain. It delivers MSB-aligned stereo PCM words with a one-cycle strobe. It sits between the board audio-in pins and the mainboard `audio_in` / service-processor `tape_audio` path, and is the inverse of the I2S transmitter used for the AK4432 DAC.

## Interface
Parameters:
- `audio_bits`, 16: width of each output PCM word.
- `i2s_mode`, 1: 1 selects standard I2S (data one BCLK after the LRCLK edge); 0 selects left-justified (data aligned to the LRCLK edge).
- `timeout_cycles`, 1024: number of `clk` cycles without a BCLK rising edge before lock is dropped.

Ports:
- `clk`, in, 1: system clock. All logic is in this domain. One clock; reset is synchronous and active-low.
- `reset_b`, in, 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `bclk`, in, 1: serial bit clock pin, asynchronous. Maximum frequency is `clk`/8.
- `lrclk`, in, 1: word select pin, asynchronous. 0 = left slot, 1 = right slot.
- `sdata`, in, 1: serial data pin, asynchronous. MSB first.
- `pcm_left`, out, `audio_bits`: last complete left word, two's complement.
- `pcm_right`, out, `audio_bits`: last complete right word.
- `pcm_valid`, out, 1: one-cycle pulse when `pcm_left` and `pcm_right` both update.
- `locked`, out, 1: high while complete frames are being received.
- `frame_err`, out, 1: one-cycle pulse when a slot ends having carried fewer than `audio_bits` bits.

## Operation
- Synchronisers: `bclk`, `lrclk` and `sdata` each pass through a 2-FF synchroniser. A third `bclk` stage provides edge detection. `rise` = synced `bclk` high and previous stage low.
- On each `rise`, sample `lr` = synced `lrclk` and `d` = synced `sdata`.
- Slot owner:
  - `i2s_mode`=1: owner = `lr` registered on the previous `rise`.
  - `i2s_mode`=0: owner = the current `lr`.
- Slot boundary: owner differs from the owner at the previous `rise`.
- Bit placement:
  - A per-slot counter `cnt` (width clog2(audio_bits)+1) tracks bits received in the current slot.
  - While `cnt` < `audio_bits`, write `d` into bit position `audio_bits-1-cnt` of the slot register, then increment `cnt`.
  - Bits beyond `audio_bits` are discarded and `cnt` saturates.
  - The slot register clears at each slot start, so short slots are zero-padded in the LSBs.
- State machine:
  - HUNT: reset state. Discards bits. On a boundary into the left slot, go to LEFT.
  - LEFT: on a boundary into the right slot, latch the left register into a holding register and go to RIGHT.
  - RIGHT: on a boundary into the left slot, drive `pcm_left` ← holding register and `pcm_right` ← right register, pulse `pcm_valid`, set `locked`, and go to LEFT.
- Boundary rules:
  - The bit sampled on a boundary `rise` belongs to the new slot and is written at MSB position with `cnt` ← 1.
  - At every boundary, if the ending slot's `cnt` < `audio_bits`, pulse `frame_err`. The word is still delivered, zero-padded. In HUNT, `frame_err` is suppressed.
- Watchdog:
  - A counter resets on every `rise` and otherwise counts up, saturating.
  - On reaching `timeout_cycles`, clear `locked` and go to HUNT. `pcm_left`/`pcm_right` hold their last values.
- Reset: `reset_b`=0 sets state HUNT and `locked`=0, `pcm_valid`=0, `frame_err`=0, `pcm_left`=0, `pcm_right`=0. Counters, slot registers and synchroniser stages all clear to 0.
- A reset asserted mid-slot discards the partial word. No `pcm_valid` is issued for it.

## Timing
- Pin-to-`rise` latency: 3 `clk` cycles (2 synchroniser stages + 1 edge register).
- `pcm_valid` and the new `pcm_left`/`pcm_right` values appear on the `clk` edge immediately after the `rise` cycle that detects the right→left boundary.
- The output registers and `pcm_valid` change in the same cycle. Data is stable until the next `pcm_valid`.
- `pcm_valid` is never high on two consecutive cycles. It is high at most once per LRCLK period.
- `frame_err` and `pcm_valid` may pulse in the same cycle.
- First `pcm_valid` after reset or lock loss: the end of the first complete left+right pair following the first left-slot boundary. This is 1–2 LRCLK periods.
- A watchdog timeout and a `rise` in the same cycle: the `rise` wins and the watchdog counter resets.

## Structure
- Put `timeout_cycles` and the state encoding (HUNT=0, LEFT=1, RIGHT=2) in the shared audio package alongside the transmitter's constants.
- Use one sub-module, `sync_edge_detect`: a 2-FF synchroniser with rise output, instantiated three times. `sdata` and `lrclk` use only its synced output.

## Test plan
- I2S source, 48 kHz, 64 BCLK/frame, left=16'h8001, right=16'h7FFE → `pcm_valid` once per frame with exact values. No `frame_err`.
- `i2s_mode`=0 against a left-justified source with the same values → identical output. The same source run with `i2s_mode`=1 → values shifted by one bit (negative test).
- 24-bit source words 24'h123456/24'hABCDEF, `audio_bits`=16 → 16'h1234/16'hABCD. 12-bit slots 12'hFFF → 16'hFFF0 with a `frame_err` pulse per slot.
- Stop BCLK mid-frame for `timeout_cycles`+10 → `locked` falls, outputs hold. Restart → first `pcm_valid` only after a full left+right pair.
- Assert `reset_b`=0 for one cycle mid-right-slot → all outputs 0, no `pcm_valid` for the partial frame, relock on the following pair.

Source files
------------

// File: rtl/i2s_audio_rx_pkg.sv
// Shared audio constants and types for the I2S receive path.
//
// Contents:
//   TIMEOUT_CYCLES : default number of clk cycles without a BCLK rising edge
//                    before the receiver drops lock.
//   I2S_SLOT_BITS  : nominal slot width used by the I2S transmitter (64 BCLK/frame).
//   rx_state_t     : receiver framing state (HUNT=0, LEFT=1, RIGHT=2).
package i2s_audio_rx_pkg;

    localparam int TIMEOUT_CYCLES = 1024;
    localparam int I2S_SLOT_BITS  = 32;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_t;

endpackage

// File: rtl/i2s_audio_rx_sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous pin, with an extra stage for
// rising-edge detection.
//
// Ports:
//   clk     : system clock
//   reset_b : synchronous active-low reset, clears all stages
//   pin     : asynchronous input pin
//   synced  : pin value after two flops
//   rise    : high for one cycle when synced goes 0 -> 1
module sync_edge_detect (
    input  logic clk,
    input  logic reset_b,
    input  logic pin,
    output logic synced,
    output logic rise
);

    logic meta;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta   <= pin;
            sync_q <= meta;
            prev_q <= sync_q;
        end
    end

    assign synced = sync_q;
    assign rise   = sync_q & ~prev_q;

endmodule

// File: rtl/i2s_audio_rx.sv
// I2S / left-justified serial audio receiver. Oversamples BCLK, LRCLK and
// SDATA in the clk domain and delivers MSB-aligned stereo PCM words.
//
// Ports:
//   clk       : system clock, all logic in this domain
//   reset_b   : synchronous active-low reset
//   bclk      : serial bit clock pin (async, <= clk/8)
//   lrclk     : word select pin (async), 0 = left, 1 = right
//   sdata     : serial data pin (async), MSB first
//   pcm_left  : last complete left word
//   pcm_right : last complete right word
//   pcm_valid : one-cycle pulse when pcm_left/pcm_right update
//   locked    : high while complete frames are being received
//   frame_err : one-cycle pulse when a slot ended with fewer than audio_bits bits
module i2s_audio_rx
    import i2s_audio_rx_pkg::*;
#(
    parameter int   audio_bits     = 16,
    parameter logic i2s_mode       = 1'b1,
    parameter int   timeout_cycles = TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  bclk,
    input  logic                  lrclk,
    input  logic                  sdata,
    output logic [audio_bits-1:0] pcm_left,
    output logic [audio_bits-1:0] pcm_right,
    output logic                  pcm_valid,
    output logic                  locked,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(audio_bits) + 1;
    localparam int WD_W  = $clog2(timeout_cycles + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(audio_bits);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(timeout_cycles);

    logic bclk_synced_unused;
    logic lr_rise_unused;
    logic sd_rise_unused;
    logic rise;
    logic lr_s;
    logic d_s;

    sync_edge_detect u_sync_bclk (
        .clk     (clk),
        .reset_b (reset_b),
        .pin     (bclk),
        .synced  (bclk_synced_unused),
        .rise    (rise)
    );

    sync_edge_detect u_sync_lrclk (
        .clk     (clk),
        .reset_b (reset_b),
        .pin     (lrclk),
        .synced  (lr_s),
        .rise    (lr_rise_unused)
    );

    sync_edge_detect u_sync_sdata (
        .clk     (clk),
        .reset_b (reset_b),
        .pin     (sdata),
        .synced  (d_s),
        .rise    (sd_rise_unused)
    );

    rx_state_t             state;
    rx_state_t             next_state;
    logic                  prev_lr;
    logic                  prev_owner;
    logic                  owner;
    logic                  boundary;
    logic                  short_slot;
    logic                  timeout;
    logic                  latch_left;
    logic                  deliver;
    logic                  err_pulse;
    logic [CNT_W-1:0]      cnt;
    logic [WD_W-1:0]       wd_cnt;
    logic [audio_bits-1:0] slot_q;
    logic [audio_bits-1:0] hold_q;

    // In standard I2S the LRCLK edge leads the data by one BCLK, so the slot
    // owner is the word-select value seen on the previous rising edge.
    assign owner      = i2s_mode ? prev_lr : lr_s;
    assign boundary   = rise && (owner != prev_owner);
    assign short_slot = (cnt < CNT_FULL);
    // A rise in the same cycle takes priority over an expiring watchdog.
    assign timeout    = !rise && (wd_cnt == WD_LIMIT);

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state <= HUNT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        latch_left = 1'b0;
        deliver    = 1'b0;
        err_pulse  = 1'b0;
        if (timeout) begin
            next_state = HUNT;
        end else if (boundary) begin
            case (state)
                HUNT: begin
                    if (!owner) begin
                        next_state = LEFT;
                    end
                end
                LEFT: begin
                    err_pulse = short_slot;
                    if (owner) begin
                        latch_left = 1'b1;
                        next_state = RIGHT;
                    end
                end
                RIGHT: begin
                    err_pulse = short_slot;
                    if (!owner) begin
                        deliver    = 1'b1;
                        next_state = LEFT;
                    end
                end
                default: next_state = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            prev_lr    <= 1'b0;
            prev_owner <= 1'b0;
            cnt        <= '0;
            slot_q     <= '0;
            hold_q     <= '0;
            wd_cnt     <= '0;
            pcm_left   <= '0;
            pcm_right  <= '0;
            pcm_valid  <= 1'b0;
            frame_err  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            if (rise) begin
                prev_lr    <= lr_s;
                prev_owner <= owner;
                if (boundary) begin
                    // The bit sampled on the boundary edge is the new slot's MSB.
                    slot_q               <= '0;
                    slot_q[audio_bits-1] <= d_s;
                    cnt                  <= CNT_W'(1);
                end else if (short_slot) begin
                    for (int i = 0; i < audio_bits; i++) begin
                        if (cnt == CNT_W'(audio_bits - 1 - i)) begin
                            slot_q[i] <= d_s;
                        end
                    end
                    cnt <= cnt + CNT_W'(1);
                end
            end

            // slot_q still holds the slot that just ended on a boundary edge.
            if (latch_left) begin
                hold_q <= slot_q;
            end
            if (deliver) begin
                pcm_left  <= hold_q;
                pcm_right <= slot_q;
            end
            pcm_valid <= deliver;
            frame_err <= err_pulse;

            if (timeout) begin
                locked <= 1'b0;
            end else if (deliver) begin
                locked <= 1'b1;
            end

            if (rise) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_LIMIT) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_i2s_audio_rx.sv
module tb_i2s_audio_rx;

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    logic bclk = 1'b1;
    logic lrclk = 1'b0;
    logic sdata = 1'b0;

    logic [15:0] pcm_left_i, pcm_right_i, pcm_left_j, pcm_right_j;
    logic pcm_valid_i, locked_i, frame_err_i;
    logic pcm_valid_j, locked_j, frame_err_j;

    always #5 clk = ~clk;

    i2s_audio_rx #(.audio_bits(16), .i2s_mode(1'b1), .timeout_cycles(1024)) dut_i2s (
        .clk(clk), .reset_b(reset_b), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .pcm_left(pcm_left_i), .pcm_right(pcm_right_i), .pcm_valid(pcm_valid_i),
        .locked(locked_i), .frame_err(frame_err_i)
    );

    i2s_audio_rx #(.audio_bits(16), .i2s_mode(1'b0), .timeout_cycles(1024)) dut_lj (
        .clk(clk), .reset_b(reset_b), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .pcm_left(pcm_left_j), .pcm_right(pcm_right_j), .pcm_valid(pcm_valid_j),
        .locked(locked_j), .frame_err(frame_err_j)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] qi_l[$], qi_r[$], qj_l[$], qj_r[$];
    int consec_i = 0, consec_j = 0, ferr_i = 0, ferr_j = 0;
    logic prev_vi = 1'b0, prev_vj = 1'b0;

    logic [31:0] fl[8];
    logic [31:0] fr[8];
    logic prev_bit = 1'b0;

    // Output monitor: records every delivered word pair, frame_err pulses and
    // any back-to-back pcm_valid.
    always @(posedge clk) begin
        #1;
        if (pcm_valid_i) begin
            qi_l.push_back(pcm_left_i);
            qi_r.push_back(pcm_right_i);
            if (prev_vi) consec_i++;
        end
        if (pcm_valid_j) begin
            qj_l.push_back(pcm_left_j);
            qj_r.push_back(pcm_right_j);
            if (prev_vj) consec_j++;
        end
        prev_vi = pcm_valid_i;
        prev_vj = pcm_valid_j;
        if (frame_err_i) ferr_i++;
        if (frame_err_j) ferr_j++;
    end

    // Expected word: first 16 bits of the slot as received, zero-padded when
    // the slot carries fewer than 16 bits.
    function automatic logic [15:0] exp_word(input logic [31:0] w, input int slot_len);
        logic [15:0] r;
        r = w[31:16];
        for (int i = 0; i < 16; i++) begin
            if (i >= slot_len) r[15-i] = 1'b0;
        end
        return r;
    endfunction

    task automatic fill_frames(input int n, input int nbits);
        for (int i = 0; i < n; i++) begin
            fl[i] = $urandom() & ~(32'hFFFF_FFFF >> nbits);
            fr[i] = $urandom() & ~(32'hFFFF_FFFF >> nbits);
        end
    endtask

    task automatic drive_bit(input logic lr, input logic d);
        bclk  = 1'b0;
        lrclk = lr;
        sdata = d;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Send bit positions [from, upto) of frame f; slot word bits are MSB first.
    task automatic send_bits(input int f, input int nbits, input int slot_len,
                             input bit i2s, input int from, input int upto);
        int s, k;
        logic [31:0] w;
        logic b;
        for (int i = from; i < upto; i++) begin
            s = i / slot_len;
            k = i % slot_len;
            w = (s != 0) ? fr[f] : fl[f];
            b = (k < nbits) ? w[31-k] : 1'b0;
            if (i2s) begin
                drive_bit(s != 0, prev_bit);
                prev_bit = b;
            end else begin
                drive_bit(s != 0, b);
            end
        end
    endtask

    task automatic send_tail(input bit i2s);
        drive_bit(1'b0, i2s ? prev_bit : 1'b0);
        prev_bit = 1'b0;
        repeat (3) drive_bit(1'b0, 1'b0);
        repeat (20) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_b = 1'b0;
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bclk = 1'b1; lrclk = 1'b0; sdata = 1'b0;
        do_reset();
        checks++; if (pcm_left_i !== 16'h0) begin errors++; $display("FAIL reset_left: got %h expected 0000", pcm_left_i); end
        checks++; if (pcm_right_i !== 16'h0) begin errors++; $display("FAIL reset_right: got %h expected 0000", pcm_right_i); end
        checks++; if (pcm_valid_i !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pcm_valid_i); end
        checks++; if (locked_i !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked_i); end
        checks++; if (frame_err_i !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err_i); end
        checks++; if (locked_j !== 1'b0) begin errors++; $display("FAIL reset_locked_lj: got %b expected 0", locked_j); end
    endtask

    task automatic test_i2s_standard();
        int base, fe, cs;
        fill_frames(5, 16);
        fl[1] = 32'h8001_0000; fr[1] = 32'h7FFE_0000;
        do_reset();
        base = qi_l.size(); fe = ferr_i; cs = consec_i;
        for (int f = 0; f < 5; f++) send_bits(f, 16, 32, 1'b1, 0, 64);
        send_tail(1'b1);
        checks++; if (qi_l.size() - base !== 4) begin errors++; $display("FAIL i2s_count: got %0d expected 4", qi_l.size() - base); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (base + k >= qi_l.size()) begin errors++; $display("FAIL i2s_word%0d: missing expected %h/%h", k, exp_word(fl[k+1], 32), exp_word(fr[k+1], 32)); end
            else if (qi_l[base+k] !== exp_word(fl[k+1], 32) || qi_r[base+k] !== exp_word(fr[k+1], 32)) begin
                errors++; $display("FAIL i2s_word%0d: got %h/%h expected %h/%h", k, qi_l[base+k], qi_r[base+k], exp_word(fl[k+1], 32), exp_word(fr[k+1], 32));
            end
        end
        checks++; if (ferr_i - fe !== 0) begin errors++; $display("FAIL i2s_frame_err: got %0d expected 0", ferr_i - fe); end
        checks++; if (consec_i - cs !== 0) begin errors++; $display("FAIL i2s_back_to_back: got %0d expected 0", consec_i - cs); end
        checks++; if (locked_i !== 1'b1) begin errors++; $display("FAIL i2s_locked: got %b expected 1", locked_i); end
    endtask

    task automatic test_left_justified();
        int bi, bj, fe;
        logic [15:0] el, er;
        fill_frames(5, 16);
        fl[1] = 32'h8001_0000; fr[1] = 32'h7FFE_0000;
        do_reset();
        bi = qi_l.size(); bj = qj_l.size(); fe = ferr_j;
        for (int f = 0; f < 5; f++) send_bits(f, 16, 32, 1'b0, 0, 64);
        send_tail(1'b0);
        checks++; if (qj_l.size() - bj !== 4) begin errors++; $display("FAIL lj_count: got %0d expected 4", qj_l.size() - bj); end
        for (int k = 0; k < 4; k++) begin
            el = exp_word(fl[k+1], 32); er = exp_word(fr[k+1], 32);
            checks++;
            if (bj + k >= qj_l.size()) begin errors++; $display("FAIL lj_word%0d: missing expected %h/%h", k, el, er); end
            else if (qj_l[bj+k] !== el || qj_r[bj+k] !== er) begin
                errors++; $display("FAIL lj_word%0d: got %h/%h expected %h/%h", k, qj_l[bj+k], qj_r[bj+k], el, er);
            end
        end
        checks++; if (ferr_j - fe !== 0) begin errors++; $display("FAIL lj_frame_err: got %0d expected 0", ferr_j - fe); end
        // The I2S-mode receiver on a left-justified source starts each slot one
        // bit late, so it sees the word shifted up by one.
        checks++; if (qi_l.size() - bi !== 4) begin errors++; $display("FAIL lj_as_i2s_count: got %0d expected 4", qi_l.size() - bi); end
        for (int k = 0; k < 4; k++) begin
            el = exp_word(fl[k+1] << 1, 32); er = exp_word(fr[k+1] << 1, 32);
            checks++;
            if (bi + k >= qi_l.size()) begin errors++; $display("FAIL lj_as_i2s_word%0d: missing expected %h/%h", k, el, er); end
            else if (qi_l[bi+k] !== el || qi_r[bi+k] !== er) begin
                errors++; $display("FAIL lj_as_i2s_word%0d: got %h/%h expected %h/%h", k, qi_l[bi+k], qi_r[bi+k], el, er);
            end
        end
    endtask

    task automatic test_wide_words();
        int base, fe;
        fill_frames(5, 24);
        fl[1] = 32'h1234_5600; fr[1] = 32'hABCD_EF00;
        do_reset();
        base = qi_l.size(); fe = ferr_i;
        for (int f = 0; f < 5; f++) send_bits(f, 24, 32, 1'b1, 0, 64);
        send_tail(1'b1);
        checks++; if (qi_l.size() - base !== 4) begin errors++; $display("FAIL wide_count: got %0d expected 4", qi_l.size() - base); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (base + k >= qi_l.size()) begin errors++; $display("FAIL wide_word%0d: missing expected %h/%h", k, exp_word(fl[k+1], 32), exp_word(fr[k+1], 32)); end
            else if (qi_l[base+k] !== exp_word(fl[k+1], 32) || qi_r[base+k] !== exp_word(fr[k+1], 32)) begin
                errors++; $display("FAIL wide_word%0d: got %h/%h expected %h/%h", k, qi_l[base+k], qi_r[base+k], exp_word(fl[k+1], 32), exp_word(fr[k+1], 32));
            end
        end
        checks++; if (ferr_i - fe !== 0) begin errors++; $display("FAIL wide_frame_err: got %0d expected 0", ferr_i - fe); end
    endtask

    task automatic test_short_slots();
        int base, fe, cs;
        fill_frames(5, 12);
        fl[1] = 32'hFFF0_0000; fr[1] = 32'hFFF0_0000;
        do_reset();
        base = qi_l.size(); fe = ferr_i; cs = consec_i;
        for (int f = 0; f < 5; f++) send_bits(f, 12, 12, 1'b1, 0, 24);
        send_tail(1'b1);
        checks++; if (qi_l.size() - base !== 4) begin errors++; $display("FAIL short_count: got %0d expected 4", qi_l.size() - base); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (base + k >= qi_l.size()) begin errors++; $display("FAIL short_word%0d: missing expected %h/%h", k, exp_word(fl[k+1], 12), exp_word(fr[k+1], 12)); end
            else if (qi_l[base+k] !== exp_word(fl[k+1], 12) || qi_r[base+k] !== exp_word(fr[k+1], 12)) begin
                errors++; $display("FAIL short_word%0d: got %h/%h expected %h/%h", k, qi_l[base+k], qi_r[base+k], exp_word(fl[k+1], 12), exp_word(fr[k+1], 12));
            end
        end
        // Every slot boundary after lock acquisition ends a 12-bit slot.
        checks++; if (ferr_i - fe !== 8) begin errors++; $display("FAIL short_frame_err: got %0d expected 8", ferr_i - fe); end
        checks++; if (consec_i - cs !== 0) begin errors++; $display("FAIL short_back_to_back: got %0d expected 0", consec_i - cs); end
    endtask

    task automatic test_timeout();
        int base;
        logic [15:0] hl, hr;
        fill_frames(4, 16);
        do_reset();
        base = qi_l.size();
        for (int f = 0; f < 3; f++) send_bits(f, 16, 32, 1'b1, 0, 64);
        send_bits(3, 16, 32, 1'b1, 0, 8);
        hl = exp_word(fl[2], 32); hr = exp_word(fr[2], 32);
        checks++; if (qi_l.size() - base !== 2) begin errors++; $display("FAIL to_count_before: got %0d expected 2", qi_l.size() - base); end
        repeat (900) @(negedge clk);
        checks++; if (locked_i !== 1'b1) begin errors++; $display("FAIL to_locked_early: got %b expected 1", locked_i); end
        repeat (140) @(negedge clk);
        checks++; if (locked_i !== 1'b0) begin errors++; $display("FAIL to_locked_dropped: got %b expected 0", locked_i); end
        checks++; if (pcm_left_i !== hl || pcm_right_i !== hr) begin errors++; $display("FAIL to_hold: got %h/%h expected %h/%h", pcm_left_i, pcm_right_i, hl, hr); end
        checks++; if (qi_l.size() - base !== 2) begin errors++; $display("FAIL to_count_idle: got %0d expected 2", qi_l.size() - base); end
        base = qi_l.size();
        fill_frames(3, 16);
        for (int f = 0; f < 3; f++) send_bits(f, 16, 32, 1'b1, 0, 64);
        send_tail(1'b1);
        checks++; if (qi_l.size() - base !== 2) begin errors++; $display("FAIL to_relock_count: got %0d expected 2", qi_l.size() - base); end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (base + k >= qi_l.size()) begin errors++; $display("FAIL to_relock_word%0d: missing expected %h/%h", k, exp_word(fl[k+1], 32), exp_word(fr[k+1], 32)); end
            else if (qi_l[base+k] !== exp_word(fl[k+1], 32) || qi_r[base+k] !== exp_word(fr[k+1], 32)) begin
                errors++; $display("FAIL to_relock_word%0d: got %h/%h expected %h/%h", k, qi_l[base+k], qi_r[base+k], exp_word(fl[k+1], 32), exp_word(fr[k+1], 32));
            end
        end
        checks++; if (locked_i !== 1'b1) begin errors++; $display("FAIL to_relocked: got %b expected 1", locked_i); end
    endtask

    task automatic test_reset_mid_slot();
        int base;
        fill_frames(4, 16);
        do_reset();
        for (int f = 0; f < 3; f++) send_bits(f, 16, 32, 1'b1, 0, 64);
        send_bits(3, 16, 32, 1'b1, 0, 42);
        @(negedge clk);
        reset_b = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
        checks++; if (pcm_left_i !== 16'h0 || pcm_right_i !== 16'h0) begin errors++; $display("FAIL mid_reset_pcm: got %h/%h expected 0000/0000", pcm_left_i, pcm_right_i); end
        checks++; if (locked_i !== 1'b0 || pcm_valid_i !== 1'b0) begin errors++; $display("FAIL mid_reset_ctrl: got locked=%b valid=%b expected 0/0", locked_i, pcm_valid_i); end
        base = qi_l.size();
        send_bits(3, 16, 32, 1'b1, 42, 64);
        fill_frames(3, 16);
        for (int f = 0; f < 3; f++) send_bits(f, 16, 32, 1'b1, 0, 64);
        send_tail(1'b1);
        checks++; if (qi_l.size() - base !== 3) begin errors++; $display("FAIL mid_reset_count: got %0d expected 3", qi_l.size() - base); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (base + k >= qi_l.size()) begin errors++; $display("FAIL mid_reset_word%0d: missing expected %h/%h", k, exp_word(fl[k], 32), exp_word(fr[k], 32)); end
            else if (qi_l[base+k] !== exp_word(fl[k], 32) || qi_r[base+k] !== exp_word(fr[k], 32)) begin
                errors++; $display("FAIL mid_reset_word%0d: got %h/%h expected %h/%h", k, qi_l[base+k], qi_r[base+k], exp_word(fl[k], 32), exp_word(fr[k], 32));
            end
        end
    endtask

    initial begin
        test_reset();
        test_i2s_standard();
        test_left_justified();
        test_wide_words();
        test_short_slots();
        test_timeout();
        test_reset_mid_slot();
        checks++; if (consec_i !== 0 || consec_j !== 0) begin errors++; $display("FAIL back_to_back_total: got %0d/%0d expected 0/0", consec_i, consec_j); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
